// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store front-end between the core memory stage and a
// simple dual-port, word-granular data BRAM (port A write, port B read with a
// one-cycle read latency). Sub-word stores are turned into read-modify-write
// sequences because the BRAM has no byte enables. Misaligned, out-of-range and
// illegal-width requests are answered with an error and never reach memory.
module dmem_access_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wea,
    output logic [31:0] mem_addra,
    output logic [31:0] mem_dina,
    output logic [31:0] mem_addrb,
    input  logic [31:0] mem_doutb
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        RESP
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state;
    state_t      next_state;

    logic        op_we;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [15:0] op_wdata;

    logic        req_err;
    logic        is_sw;
    logic [31:0] word_addr;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign is_sw     = req_we && (req_funct3 == 3'b010);
    assign word_addr = {req_addr[31:2], 2'b00};

    // Classify the incoming request: illegal width, misalignment or out of range.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = (req_addr[1:0] != 2'b00);
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we || req_addr[0];
            default: req_err = 1'b1;
        endcase
        if (req_addr >= MEM_LIMIT) begin
            req_err = 1'b1;
        end
    end

    // Next-state logic and state-decoded handshake / write-enable outputs.
    always_comb begin
        next_state = state;
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_wea    = (state == WR);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (is_sw) begin
                        next_state = WR;
                    end else begin
                        next_state = RD_ADDR;
                    end
                end
            end
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: next_state = op_we ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lane selection, load extension and sub-word merge on the returned BRAM word.
    always_comb begin
        rd_byte   = 8'h00;
        rd_half   = op_off[1] ? mem_doutb[31:16] : mem_doutb[15:0];
        load_data = mem_doutb;
        merged    = mem_doutb;
        case (op_off)
            2'd0:    rd_byte = mem_doutb[7:0];
            2'd1:    rd_byte = mem_doutb[15:8];
            2'd2:    rd_byte = mem_doutb[23:16];
            default: rd_byte = mem_doutb[31:24];
        endcase
        case (op_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h000000, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0000, rd_half};
            default: load_data = mem_doutb;
        endcase
        if (op_funct3[1:0] == 2'b00) begin
            case (op_off)
                2'd0:    merged[7:0]   = op_wdata[7:0];
                2'd1:    merged[15:8]  = op_wdata[7:0];
                2'd2:    merged[23:16] = op_wdata[7:0];
                default: merged[31:24] = op_wdata[7:0];
            endcase
        end else if (op_funct3[1:0] == 2'b01) begin
            if (op_off[1]) begin
                merged[31:16] = op_wdata;
            end else begin
                merged[15:0] = op_wdata;
            end
        end
    end

    // State register; reset aborts any operation in flight, including a write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture, BRAM address/data registers and the held response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_we      <= 1'b0;
            op_funct3  <= 3'b000;
            op_off     <= 2'b00;
            op_wdata   <= 16'h0000;
            mem_addra  <= 32'h0;
            mem_dina   <= 32'h0;
            mem_addrb  <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_off    <= req_addr[1:0];
                        op_wdata  <= req_wdata[15:0];
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (is_sw) begin
                            mem_addra <= word_addr;
                            mem_dina  <= req_wdata;
                        end else begin
                            mem_addrb <= word_addr;
                            if (req_we) begin
                                mem_addra <= word_addr;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (op_we) begin
                        mem_dina <= merged;
                    end else begin
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench with a byte-level reference memory.
// The driver predicts each response at acceptance and queues it; a monitor
// checks BRAM writes and responses as the unit produces them.
module tb_dmem_access_unit;

    localparam int MEM_BYTES = 4096;
    localparam int WORDS     = MEM_BYTES / 4;
    localparam int AW        = $clog2(MEM_BYTES);

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wea;
    logic [31:0] mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_addrb;
    logic [31:0] mem_doutb = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        int          accept_idx;
        logic [31:0] waddr;
        logic [31:0] wword;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] bram [WORDS];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          wea_count = 0;
    bit          prev_hold = 1'b0;
    int          prev_idx = 0;
    int          prev_lat = 0;
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    dmem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_addrb  (mem_addrb),
        .mem_doutb  (mem_doutb)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure response latency.
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural BRAM: port A write, port B registered read.
    always @(posedge clk) begin
        if (mem_wea) bram[mem_addra[AW-1:2]] <= mem_dina;
        mem_doutb <= bram[mem_addrb[AW-1:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit refIsErr(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (addr >= 32'(MEM_BYTES)) return 1'b1;
        if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) return 1'b1;
        if (f3 == 3'b010 && addr[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: byte-addressed memory, predicts response and write word.
    function automatic exp_t refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int idx, input bit commit);
        exp_t e;
        logic [7:0] w [4];
        int base;
        int off;
        int n;
        e.accept_idx = idx;
        e.rdata = 32'h0;
        e.err = 1'b0;
        e.writes = 0;
        e.waddr = 32'h0;
        e.wword = 32'h0;
        e.lat = 1;
        if (refIsErr(we, f3, addr)) begin
            e.err = 1'b1;
            return e;
        end
        base = int'(addr) & ~3;
        off = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) w[i] = ref_mem[base + i];
        if (we) begin
            n = 1 << f3[1:0];
            for (int i = 0; i < n; i++) w[off + i] = wdata[8*i +: 8];
            e.writes = 1;
            e.waddr = addr & ~32'h3;
            e.wword = {w[3], w[2], w[1], w[0]};
            e.lat = (f3 == 3'b010) ? 2 : 4;
            if (commit) for (int i = 0; i < 4; i++) ref_mem[base + i] = w[i];
        end else begin
            e.lat = 3;
            case (f3)
                3'b000:  e.rdata = {{24{w[off][7]}}, w[off]};
                3'b100:  e.rdata = {24'h0, w[off]};
                3'b001:  e.rdata = {{16{w[off+1][7]}}, w[off+1], w[off]};
                3'b101:  e.rdata = {16'h0, w[off+1], w[off]};
                default: e.rdata = {w[3], w[2], w[1], w[0]};
            endcase
        end
        return e;
    endfunction

    // Present one request and wait for acceptance; hold keeps req_valid high afterwards.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold, input bit commit);
        int guard = 0;
        int idx;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
                req_valid = 1'b0;
                prev_hold = 1'b0;
                return;
            end
        end
        idx = cycle + 1;
        if (prev_hold) checkOutput("accept_gap", 32'(idx), 32'(prev_idx + prev_lat + 1));
        e = refModel(we, f3, addr, wdata, idx, commit);
        sb_q.push_back(e);
        prev_hold = hold;
        prev_idx = idx;
        prev_lat = e.lat;
        @(posedge clk);
        if (!hold) #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_pending", 32'(sb_q.size()), 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        prev_hold = 1'b0;
    endtask

    // Monitor: checks every BRAM write and every response against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                wea_count = 0;
            end else begin
                if (mem_wea) begin
                    wea_count++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_write: got mem_wea=1 expected 0 (addr 0x%08h)", mem_addra);
                    end else begin
                        checkOutput("mem_addra", mem_addra, sb_q[0].waddr);
                        checkOutput("mem_dina", mem_dina, sb_q[0].wword);
                    end
                end
                if (resp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_resp: got resp_valid=1 expected 0");
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("resp_rdata", resp_rdata, e.rdata);
                        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
                        checkOutput("latency", 32'(cycle - e.accept_idx + 1), 32'(e.lat));
                        checkOutput("write_count", 32'(wea_count), 32'(e.writes));
                    end
                    wea_count = 0;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed test-plan cases, reset abort, back-to-back, random.
    initial begin
        logic [31:0] word;
        logic [31:0] addr;
        logic [2:0]  f3;
        int r;
        for (int i = 0; i < WORDS; i++) begin
            word = $urandom;
            bram[i] = word;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = word[8*b +: 8];
        end

        #3 rstn = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_mem_wea", 32'(mem_wea), 32'h0);
        checkOutput("rst_mem_addra", mem_addra, 32'h0);
        checkOutput("rst_mem_addrb", mem_addrb, 32'h0);
        checkOutput("rst_mem_dina", mem_dina, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h000000AA, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'b001, 32'h21, 32'h1234, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'(MEM_BYTES), 32'h0, 1'b0, 1'b1);
        drain();
        checkOutput("word_0x10", bram[4], 32'hDEADAAEF);

        word = bram[16];
        applyStimulus(1'b1, 3'b001, 32'h42, 32'h0000C0DE, 1'b0, 1'b0);
        r = 0;
        while (!mem_wea && r < 10) begin
            @(negedge clk);
            r++;
        end
        checkOutput("reach_wr", 32'(mem_wea), 32'h1);
        #2 rstn = 1'b0;
        #1 checkOutput("wea_async_drop", 32'(mem_wea), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        sb_q.delete();
        rstn = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
        checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("abort_word_kept", bram[16], word);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b1);
        drain();

        applyStimulus(1'b1, 3'b010, 32'h20, 32'h89ABCDEF, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'b000, 32'h23, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h00007F01, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h21, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'b000, 32'h20, 32'h000000FF, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'b100, 32'h24, 32'h5, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1);
        drain();

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 15);
            if (r < 13) f3 = legal_f3[r % 5];
            else f3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            if (r == 0) addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
            else if (r == 1) addr = $urandom;
            else addr = 32'($urandom_range(0, 127));
            applyStimulus(1'($urandom_range(0, 1)), f3, addr, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        for (int i = 0; i < 32; i++) begin
            checkOutput("final_mem", bram[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store front-end between the core's memory stage and the data-memory BRAM wrapper (simple dual-port: port A write, port B read, 1-cycle read latency, single-bit write enable, word-granular).
- Accepts one RV32 load/store at a time and performs sign/zero extension for loads.
- Sub-word stores become read-modify-write sequences because the BRAM has no byte enables.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 4096, size of data memory in bytes (power of two); byte addresses >= MEM_BYTES are out of range.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for b/h)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned / out-of-range / illegal funct3
- mem_wea  out  1  BRAM port A write enable
- mem_addra  out  32  BRAM write byte address (word aligned, [1:0]=0)
- mem_dina  out  32  BRAM write data
- mem_addrb  out  32  BRAM read byte address (word aligned)
- mem_doutb  in  32  BRAM read data, valid one cycle after mem_addrb is presented

Behaviour:
- Reset (async, rstn=0): state IDLE; all registers 0; req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0, mem_wea=0, mem_addra=mem_addrb=mem_dina=0.
- Reset mid-operation aborts immediately: mem_wea drops asynchronously, no partial write after reset, pending response discarded.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- req_ready=1 only in IDLE. Acceptance is req_valid&req_ready at edge T; op, addr, wdata latched. Request inputs are ignored outside IDLE.
- Error check at acceptance:
  - h/hu/sh with addr[0]=1 → error.
  - w/sw with addr[1:0]!=0 → error.
  - addr >= MEM_BYTES → error.
  - funct3 not in {000,001,010,100,101}, or store with funct3 in {100,101} → error.
  - Error: next state RESP, resp_err=1, resp_rdata=0, no BRAM activity.
- IDLE transitions: sw → WR (merged = wdata); loads, sb, sh → RD_ADDR.
- RD_ADDR: mem_addrb = {addr[31:2],2'b00} (registered, held stable until next accept) → RD_DATA.
- RD_DATA: mem_doutb sampled.
  - Load: select byte addr[1:0] / halfword addr[1], sign-extend (b,h) or zero-extend (bu,hu); w passes through; result → RESP.
  - sb/sh: replace selected byte/halfword of mem_doutb with wdata[7:0]/[15:0], other bytes unchanged → WR.
- WR: mem_wea=1 for exactly one cycle; mem_addra = word address; mem_dina = merged → RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err → IDLE.
  - No response backpressure; the core must consume the pulse.
  - resp_rdata/resp_err hold until the next RESP.
- Latency from accept edge T: error resp at T+1; sw resp at T+2 (write at T+1); load resp at T+3; sb/sh resp at T+4 (write at T+3).
- One outstanding request only, so no read-during-write hazard: a write completes before the next accept.
- Back-to-back: a new request may be accepted in the cycle after RESP (IDLE).
- mem_wea is 0 in every state except WR. Address bits above log2(MEM_BYTES) are passed unmodified but are always 0 for legal accesses.

Test Plan:
- Reset then sw addr=0x10 wdata=0xDEADBEEF → mem_wea=1 one cycle at T+1, mem_addra=0x10, mem_dina=0xDEADBEEF; resp_valid at T+2, resp_err=0.
- lb addr=0x13 (mem word 0xDEADBEEF) → resp_rdata=0xFFFFFFDE at T+3; lbu same → 0x000000DE; lh addr=0x10 → 0xFFFFBEEF; lhu addr=0x12 → 0x0000DEAD.
- sb addr=0x11 wdata=0x000000AA over 0xDEADBEEF → read at T+1, write mem_dina=0xDEADAAEF at T+3, resp at T+4; subsequent lw addr=0x10 → 0xDEADAAEF.
- lw addr=0x12, sh addr=0x21, and lw addr=MEM_BYTES → each gives resp_valid at T+1 with resp_err=1 and resp_rdata=0; mem_wea never asserts.
- Assert rstn=0 while in WR during sh → mem_wea drops asynchronously; memory word unchanged; after release req_ready=1 and resp_valid=0.
- Hold req_valid=1 with 8 back-to-back mixed requests → req_ready low while busy, each request serviced exactly once in order, responses match a reference memory model.
